// File: rtl/pong_score_keeper.sv
// Match controller for pong: BCD scores, IDLE/PLAY/PAUSE/OVER sequencing, and ball run-enable.
// Optional feature macro WIN_BY_TWO_EN: a win also needs a 2-point lead (99 always wins).
module pong_score_keeper #(
    parameter int WIN_SCORE    = 11,
    parameter int PAUSE_CYCLES = 25000000,
    parameter int START        = 103,
    parameter int RESTART      = 98
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic [7:0] i_key_byte,
    input  logic       i_p1_scored,
    input  logic       i_p2_scored,
    output logic       o_ball_enable,
    output logic [3:0] o_p1_tens,
    output logic [3:0] o_p1_ones,
    output logic [3:0] o_p2_tens,
    output logic [3:0] o_p2_ones,
    output logic       o_game_over,
    output logic [1:0] o_winner,
    output logic [1:0] o_state
);

    localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [6:0]       WIN_BIN    = 7'(WIN_SCORE);
    localparam logic [7:0]       KEY_START  = 8'(START);
    localparam logic [7:0]       KEY_RESTART = 8'(RESTART);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       p1_q, p1_d, p2_q, p2_d;
    logic [7:0]       p1_inc, p2_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       winner_q, winner_d;
    logic             ball_en_q, game_over_q;
    logic             p1_hist_p0, p2_hist_p0;
    logic             p1_evt, p2_evt;
    logic             p1_wins, p2_wins;
    logic             key_start, key_restart;

    // Scores are packed BCD {tens, ones}; increment carries 9->10 and sticks at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

`ifdef WIN_BY_TWO_EN
    function automatic logic is_win(input logic [7:0] mine, input logic [7:0] theirs);
        logic [6:0] m;
        logic [6:0] t;
        m = bcd_to_bin(mine);
        t = bcd_to_bin(theirs);
        return (m == 7'd99) || ((m >= WIN_BIN) && ({1'b0, m} >= ({1'b0, t} + 8'd2)));
    endfunction
`endif

    assign key_start   = (i_key_byte == KEY_START);
    assign key_restart = (i_key_byte == KEY_RESTART);
    assign p1_evt      = i_p1_scored & ~p1_hist_p0;
    assign p2_evt      = i_p2_scored & ~p2_hist_p0;
    assign p1_inc      = bcd_inc_sat(p1_q);
    assign p2_inc      = bcd_inc_sat(p2_q);

`ifdef WIN_BY_TWO_EN
    assign p1_wins = is_win(p1_inc, p2_q);
    assign p2_wins = is_win(p2_inc, p1_q);
`else
    assign p1_wins = (bcd_to_bin(p1_inc) >= WIN_BIN);
    assign p2_wins = (bcd_to_bin(p2_inc) >= WIN_BIN);
`endif

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        if (key_restart) begin
            state_d  = S_IDLE;
            p1_d     = 8'h00;
            p2_d     = 8'h00;
            cnt_d    = '0;
            winner_d = 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_start)
                        state_d = S_PLAY;
                end
                S_PLAY: begin
                    // Player 1 wins a tie on the same clock; player 2's edge is dropped.
                    if (p1_evt) begin
                        p1_d = p1_inc;
                        if (p1_wins) begin
                            state_d  = S_OVER;
                            winner_d = 2'b01;
                        end else begin
                            state_d = S_PAUSE;
                            cnt_d   = PAUSE_LOAD;
                        end
                    end else if (p2_evt) begin
                        p2_d = p2_inc;
                        if (p2_wins) begin
                            state_d  = S_OVER;
                            winner_d = 2'b10;
                        end else begin
                            state_d = S_PAUSE;
                            cnt_d   = PAUSE_LOAD;
                        end
                    end
                end
                S_PAUSE: begin
                    if (cnt_q == '0)
                        state_d = S_PLAY;
                    else
                        cnt_d = cnt_q - CNT_ONE;
                end
                S_OVER: begin
                    if (key_start) begin
                        state_d  = S_IDLE;
                        p1_d     = 8'h00;
                        p2_d     = 8'h00;
                        winner_d = 2'b00;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q     <= S_IDLE;
            p1_q        <= 8'h00;
            p2_q        <= 8'h00;
            cnt_q       <= '0;
            winner_q    <= 2'b00;
            ball_en_q   <= 1'b0;
            game_over_q <= 1'b0;
            p1_hist_p0  <= 1'b0;
            p2_hist_p0  <= 1'b0;
        end else begin
            state_q     <= state_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            cnt_q       <= cnt_d;
            winner_q    <= winner_d;
            ball_en_q   <= (state_d == S_PLAY);
            game_over_q <= (state_d == S_OVER);
            p1_hist_p0  <= i_p1_scored;
            p2_hist_p0  <= i_p2_scored;
        end
    end

    assign o_ball_enable = ball_en_q;
    assign o_game_over   = game_over_q;
    assign o_winner      = winner_q;
    assign o_state       = state_q;
    assign o_p1_tens     = p1_q[7:4];
    assign o_p1_ones     = p1_q[3:0];
    assign o_p2_tens     = p2_q[7:4];
    assign o_p2_ones     = p2_q[3:0];

endmodule

// File: tb/tb_pong_score_keeper.sv
// Scoreboard bench for pong_score_keeper: directed match scenarios plus randomized play.
module tb_pong_score_keeper;

    localparam int WIN       = 11;
    localparam int PC        = 4;
    localparam int K_START   = 103;
    localparam int K_RESTART = 98;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key;
    logic       pa, pb;
    logic       ball_en, game_over;
    logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
    logic [1:0] winner, state;

    always #5 clk = ~clk;

    pong_score_keeper #(
        .WIN_SCORE(WIN), .PAUSE_CYCLES(PC), .START(K_START), .RESTART(K_RESTART)
    ) dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_key_byte(key),
        .i_p1_scored(pa), .i_p2_scored(pb),
        .o_ball_enable(ball_en),
        .o_p1_tens(p1_tens), .o_p1_ones(p1_ones),
        .o_p2_tens(p2_tens), .o_p2_ones(p2_ones),
        .o_game_over(game_over), .o_winner(winner), .o_state(state)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       go;
        logic [1:0] win;
        logic [7:0] s1;
        logic [7:0] s2;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: plain integer scores, mode 0 idle / 1 play / 2 pause / 3 over.
    int m_mode, m_s1, m_s2, m_win, m_left;
    bit m_prev1, m_prev2;

    function automatic void model_reset();
        m_mode = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_left = 0;
        m_prev1 = 0; m_prev2 = 0;
    endfunction

    function automatic bit won(int me, int opp);
`ifdef WIN_BY_TWO_EN
        return (me == 99) || (me >= WIN && me - opp >= 2);
`else
        return me >= WIN;
`endif
    endfunction

    function automatic void model_step(logic [7:0] k, bit a, bit b);
        bit ev1, ev2;
        ev1 = a && !m_prev1;
        ev2 = b && !m_prev2;
        m_prev1 = a;
        m_prev2 = b;
        if (k == 8'(K_RESTART)) begin
            m_mode = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_left = 0;
        end else if (m_mode == 0) begin
            if (k == 8'(K_START)) m_mode = 1;
        end else if (m_mode == 1) begin
            if (ev1) begin
                m_s1 = (m_s1 + 1 > 99) ? 99 : m_s1 + 1;
                if (won(m_s1, m_s2)) begin m_mode = 3; m_win = 1; end
                else begin m_mode = 2; m_left = PC; end
            end else if (ev2) begin
                m_s2 = (m_s2 + 1 > 99) ? 99 : m_s2 + 1;
                if (won(m_s2, m_s1)) begin m_mode = 3; m_win = 2; end
                else begin m_mode = 2; m_left = PC; end
            end
        end else if (m_mode == 2) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 1;
        end else begin
            if (k == 8'(K_START)) begin
                m_mode = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.st  = 2'(m_mode);
        e.en  = (m_mode == 1);
        e.go  = (m_mode == 3);
        e.win = 2'(m_win);
        e.s1  = {4'(m_s1 / 10), 4'(m_s1 % 10)};
        e.s2  = {4'(m_s2 / 10), 4'(m_s2 % 10)};
        return e;
    endfunction

    function automatic void check_now(string name, exp_t e);
        exp_t got;
        got = {state, ball_en, game_over, winner, p1_tens, p1_ones, p2_tens, p2_ones};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got st=%b en=%b go=%b win=%b p1=%h p2=%h, want st=%b en=%b go=%b win=%b p1=%h p2=%h",
                     name, $time, got.st, got.en, got.go, got.win, got.s1, got.s2,
                     e.st, e.en, e.go, e.win, e.s1, e.s2);
        end
    endfunction

    // Monitor: the registered outputs are settled 1 time unit after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check_now("cycle", e);
        end
    end

    task automatic cycle(input logic [7:0] k, input logic a, input logic b);
        key = k; pa = a; pb = b;
        model_step(k, a, b);
        q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic point(input int who);
        cycle(8'h00, who == 1, who == 2);
        repeat (PC + 1) cycle(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        logic la, lb;
        logic [7:0] k;
        int r;
        rst_n = 1'b0; key = 8'h00; pa = 1'b0; pb = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_now("reset_held", model_out());
        rst_n = 1'b1;
        repeat (10) cycle(8'h00, 1'b0, 1'b0);

        // First point, exact pause length, held pulse, simultaneous pulses.
        cycle(8'(K_START), 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b0);
        repeat (PC + 1) cycle(8'h00, 1'b0, 1'b0);
        repeat (20) cycle(8'h00, 1'b0, 1'b1);
        repeat (PC + 1) cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h00, 1'b1, 1'b1);
        repeat (PC + 1) cycle(8'h00, 1'b0, 1'b0);

        // Drive to 10:10 (tens carry), then 11:10 and onward to 13:11.
        while (m_s1 < 10) point(1);
        while (m_s2 < 10) point(2);
        point(1);
        point(2);
        point(1);
        point(1);

        // Held START leaves OVER then starts; RESTART beats a same-cycle score event.
        cycle(8'(K_START), 1'b0, 1'b0);
        cycle(8'(K_START), 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'(K_RESTART), 1'b1, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);

        // Asynchronous reset asserted away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_now("async_reset", model_out());
        @(negedge clk);
        rst_n = 1'b1;
        key = 8'h00; pa = 1'b0; pb = 1'b0;

        la = 1'b0; lb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 299);
            if (r == 0)
                k = 8'(K_RESTART);
            else if (r < 40)
                k = 8'(K_START);
            else begin
                k = 8'($urandom);
                if (k == 8'(K_START) || k == 8'(K_RESTART)) k = 8'h00;
            end
            if ($urandom_range(0, 3) == 0) la = ~la;
            if ($urandom_range(0, 3) == 0) lb = ~lb;
            cycle(k, la, lb);
        end

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pong_score_keeper.md
Name: pong_score_keeper

Overview:
- Match controller that consumes the per-point score pulses from the ball logic and the key bytes from the keyboard path.
- Keeps both players' scores in BCD and runs the match state machine: idle, play, post-point pause, game over.
- Drives the ball run-enable back to the ball logic, plus the score digits and winner flag for the scoreboard renderer.

Parameters:
- WIN_SCORE, 11, points needed to win; legal range 1..99.
- PAUSE_CYCLES, 25000000, length of the post-point pause in clocks (1 s at 25 MHz); minimum 1.
- START, 103, key byte that starts a match ('g').
- RESTART, 98, key byte that aborts to idle and clears scores ('b').

Ports:
- i_CLK  in  1  system clock
- i_RST_N  in  1  asynchronous active-low reset
- i_key_byte  in  8  latest key code from the keyboard path
- i_p1_scored  in  1  player 1 point pulse; level, rising-edge detected
- i_p2_scored  in  1  player 2 point pulse; level, rising-edge detected
- o_ball_enable  out  1  1 = ball may move; 0 = ball held at centre
- o_p1_tens  out  4  player 1 score, BCD tens digit
- o_p1_ones  out  4  player 1 score, BCD ones digit
- o_p2_tens  out  4  player 2 score, BCD tens digit
- o_p2_ones  out  4  player 2 score, BCD ones digit
- o_game_over  out  1  high while in OVER
- o_winner  out  2  00 none, 01 player 1, 10 player 2
- o_state  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER

Behaviour:
- Reset (i_RST_N low, asynchronous):
  - state IDLE; all score digits 0.
  - o_ball_enable, o_game_over, o_winner all 0.
  - edge-detect history registers cleared to 0; pause counter cleared to 0.
- Reset release takes effect on the next i_CLK rising edge.
- All outputs are registered.
- Edge detect: an event is registered when the input is sampled high and was sampled low on the previous clock.
  - A held-high pulse counts once.
  - History registers update in every state, so a pulse already high when PLAY is entered does not count.
- IDLE:
  - o_ball_enable = 0; scores held at 0.
  - i_key_byte == START → PLAY.
- PLAY:
  - o_ball_enable = 1.
  - On a p1 or p2 event, that player's score increments by 1 in BCD: ones 9→0 carries into tens; saturates at 99.
  - If the new score ≥ WIN_SCORE → OVER, o_winner set to the scorer.
  - Otherwise → PAUSE, with the counter loaded to PAUSE_CYCLES-1.
  - Score, state and enable all change on the same edge: visible one clock after the input's first high sample.
- Simultaneous p1 and p2 events in the same cycle: p1 is awarded, p2 is discarded.
- PAUSE:
  - o_ball_enable = 0; score events are ignored.
  - Counter decrements each clock; when the counter is 0 → PLAY.
  - Total PAUSE dwell is exactly PAUSE_CYCLES clocks.
- OVER:
  - o_ball_enable = 0; o_game_over = 1; scores and o_winner held; events ignored.
  - START → IDLE with scores and winner cleared; a second START is required to play.
- RESTART in any state:
  - → IDLE next edge; scores, winner and counter cleared.
  - Has priority over a score event or counter expiry in the same cycle.
- Any i_key_byte value other than START or RESTART has no effect.
- A constant i_key_byte == START (the keyboard path holds the last byte) causes no repeated action in PLAY or PAUSE.
- Held START in OVER moves to IDLE, then immediately to PLAY on the following edge; this is accepted behaviour.

Optional Feature:
- Macro: WIN_BY_TWO_EN.
- When defined, a win requires score ≥ WIN_SCORE and a lead of at least 2 over the opponent.
- A player reaching 99 wins unconditionally; otherwise the point goes to PAUSE.
- When undefined, the win is declared at first score ≥ WIN_SCORE regardless of margin.

Test Plan:
- Reset held, then released with i_key_byte=0 → state 00, all digits 0, o_ball_enable 0, o_winner 00, for 10 clocks.
- Bench uses PAUSE_CYCLES=4. START, then a 1-clock p1 pulse → next clock: o_p1_ones=1, state PAUSE, enable 0. Exactly 4 clocks later → state PLAY, enable 1.
- p2 held high for 20 clocks during PLAY → o_p2_ones increments exactly once.
- p1 and p2 pulsed on the same clock → p1 +1, p2 unchanged.
- Score 9 for p1, then another p1 event → o_p1_tens=1, o_p1_ones=0.
- WIN_SCORE=11 without the macro: p1 reaches 11 while p2 has 10 → OVER, o_winner=01, o_game_over=1. A RESTART injected on the same cycle as a score event instead gives IDLE with 0:0.
- With WIN_BY_TWO_EN defined and p1 at 11, p2 at 10 → state is PAUSE, no win. Further points to 13:11 → OVER, o_winner=01.
